operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 211 +++++++++++++++++++++
 tb/tb_operand_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Register-file read stage in front of an ALU. Holds 2^ADDR_W x 32-bit
//   registers (register 0 hard-wired to zero), a busy-bit scoreboard that
//   tracks registers with an outstanding write-back, and a one-entry output
//   register carrying opcode, operands and destination to the ALU.
//
//   Configuration macro: OPFETCH_BYPASS_EN
//     defined   -> a write-back arriving in the same cycle as a read of a
//                  busy source register is forwarded into the operand and
//                  the source is not treated as a hazard.
//     undefined -> no forwarding; the instruction issues one cycle after the
//                  write-back, reading the updated register file.
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction input handshake
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  // ALU result write-back
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  // ALU-side handshake and registered operands
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [31:0]       out_A,
  output logic [31:0]       out_B,
  output logic [ADDR_W-1:0] out_rd
);

  localparam int NREG = 1 << ADDR_W;

`ifdef OPFETCH_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  // Sign-extend the 16-bit immediate to operand width.
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    sext16 = {{16{imm[15]}}, imm};
  endfunction

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [31:0]       r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic              r_out_valid;
  logic [7:0]        r_out_opcode;
  logic [31:0]       r_out_a;
  logic [31:0]       r_out_b;
  logic [ADDR_W-1:0] r_out_rd;

  // ------------------------------------------------------------------------
  // Combinational read / hazard / handshake signals
  // ------------------------------------------------------------------------
  logic [31:0]       w_rs_data;
  logic [31:0]       w_rt_data;
  logic              w_fwd_rs;
  logic              w_fwd_rt;
  logic              w_rs_haz;
  logic              w_rt_haz;
  logic              w_hazard;
  logic [31:0]       w_op_a;
  logic [31:0]       w_op_b;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_wb_write;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_busy_nxt;

  // Register-file read ports; register 0 always reads as zero.
  always_comb begin
    w_rs_data = 32'h0000_0000;
    w_rt_data = 32'h0000_0000;
    if (in_rs != '0) begin
      w_rs_data = r_regs[in_rs];
    end else begin
      w_rs_data = 32'h0000_0000;
    end
    if (in_rt != '0) begin
      w_rt_data = r_regs[in_rt];
    end else begin
      w_rt_data = 32'h0000_0000;
    end
  end

  // Forwarding decision and hazard detection. Register 0 is never busy, so
  // it can never raise a hazard or be forwarded.
  always_comb begin
    w_fwd_rs = BYPASS & wb_en & (wb_addr == in_rs) & (in_rs != '0) & r_busy[in_rs];
    w_fwd_rt = BYPASS & wb_en & (wb_addr == in_rt) & (in_rt != '0) & r_busy[in_rt];
    w_rs_haz = r_busy[in_rs] & ~w_fwd_rs;
    w_rt_haz = ~in_use_imm & r_busy[in_rt] & ~w_fwd_rt;
    w_hazard = w_rs_haz | w_rt_haz;
  end

  // Operand selection: forwarded write-back data, register file, or immediate.
  always_comb begin
    w_op_a = w_rs_data;
    w_op_b = w_rt_data;
    if (w_fwd_rs) begin
      w_op_a = wb_data;
    end else begin
      w_op_a = w_rs_data;
    end
    if (in_use_imm) begin
      w_op_b = sext16(in_imm);
    end else if (w_fwd_rt) begin
      w_op_b = wb_data;
    end else begin
      w_op_b = w_rt_data;
    end
  end

  // Input handshake: accept when hazard-free and the output slot is free or
  // draining this cycle; nothing is accepted while reset is asserted.
  always_comb begin
    w_in_ready = ~rst & ~w_hazard & (~r_out_valid | out_ready);
    w_accept   = in_valid & w_in_ready;
    w_wb_write = wb_en & (wb_addr != '0);
  end

  // Scoreboard next state: issue sets the destination bit, write-back clears
  // its bit, and a same-cycle set on the same register takes priority.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_accept && (in_rd != '0)) begin
      w_set_mask[in_rd] = 1'b1;
    end else begin
      w_set_mask = '0;
    end
    if (wb_en) begin
      w_clr_mask[wb_addr] = 1'b1;
    end else begin
      w_clr_mask = '0;
    end
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  // ------------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------------

  // Register file write port; writes to register 0 are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else if (w_wb_write) begin
      r_regs[wb_addr] <= wb_data;
    end else begin
      r_regs[0] <= 32'h0000_0000;
    end
  end

  // Busy-bit scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Output register: load on acceptance, drop valid once consumed, and hold
  // every field while the ALU stage back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_opcode <= 8'h00;
      r_out_a      <= 32'h0000_0000;
      r_out_b      <= 32'h0000_0000;
      r_out_rd     <= '0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= in_opcode;
      r_out_a      <= w_op_a;
      r_out_b      <= w_op_b;
      r_out_rd     <= in_rd;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid  <= r_out_valid;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_opcode = r_out_opcode;
  assign out_A      = r_out_a;
  assign out_B      = r_out_b;
  assign out_rd     = r_out_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//   Directed, table-driven bench for operand_fetch (ADDR_W = 4). Each table
//   row drives the inputs for one clock cycle, checks in_ready before the
//   rising edge and the registered outputs after it. Expectations for the
//   forwarding cycles depend on OPFETCH_BYPASS_EN. Two hand-written
//   sequences follow: a hazard on source B resolved by write-back, and a
//   reset during a stall.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [3:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [31:0] out_A, out_B;
  logic [3:0]  out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_A(out_A), .out_B(out_B), .out_rd(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, iv;
    logic [7:0]  op;
    logic [3:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        ui, wbe;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        e_rdy, e_ov;
    logic [7:0]  e_op;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_rd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic iv, input logic [7:0] op,
                     input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                     input logic [15:0] imm, input logic ui,
                     input logic wbe, input logic [3:0] wba, input logic [31:0] wbd,
                     input logic ordy,
                     input logic e_rdy, input logic e_ov, input logic [7:0] e_op,
                     input logic [31:0] e_a, input logic [31:0] e_b, input logic [3:0] e_rd);
    vec_t v;
    v.rst = r; v.iv = iv; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
    v.imm = imm; v.ui = ui; v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_op = e_op; v.e_a = e_a; v.e_b = e_b; v.e_rd = e_rd;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_opcode = 8'h00; in_rs = 4'd0; in_rt = 4'd0; in_rd = 4'd0;
    in_imm = 16'h0000; in_use_imm = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'h0;
  endtask

  int acc_cycle;
  int exp_cycle;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();

    //   rst iv op     rs rt rd imm      ui wbe wba wbd            ordy | rdy ov op     A              B              rd
    add(1, 0, 8'h00,  0, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0,     0, 0, 8'h00, 32'h0,         32'h0,         0); // 0 reset
    add(0, 0, 8'h00,  0, 0, 0, 16'h0000, 0, 1, 3, 32'h5,          1,     1, 0, 8'h00, 32'h0,         32'h0,         0); // 1 r3=5
    add(0, 1, 8'h00,  3, 0, 4, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h00, 32'h5,         32'h0,         4); // 2 issue rd4
    add(0, 1, 8'h11,  0, 0, 0, 16'hFFF0, 1, 0, 0, 32'h0,          1,     1, 1, 8'h11, 32'h0,         32'hFFFF_FFF0, 0); // 3 imm sext
    add(0, 1, 8'h22,  4, 0, 5, 16'h0000, 0, 0, 0, 32'h0,          1,     0, 0, 8'h11, 32'h0,         32'hFFFF_FFF0, 0); // 4 rs4 busy
    add(0, 1, 8'hEE,  4, 1, 9, 16'h1234, 0, 0, 0, 32'h0,          1,     0, 0, 8'h11, 32'h0,         32'hFFFF_FFF0, 0); // 5 stalled, ignored
`ifdef OPFETCH_BYPASS_EN
    add(0, 1, 8'h22,  4, 0, 5, 16'h0000, 0, 1, 4, 32'h1234,       1,     1, 1, 8'h22, 32'h1234,      32'h0,         5); // 6 forwarded
`else
    add(0, 1, 8'h22,  4, 0, 5, 16'h0000, 0, 1, 4, 32'h1234,       1,     0, 0, 8'h11, 32'h0,         32'hFFFF_FFF0, 0); // 6 still stalled
`endif
    add(0, 1, 8'h22,  4, 0, 5, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h22, 32'h1234,      32'h0,         5); // 7 from regfile
    add(0, 1, 8'h33,  3, 4, 6, 16'h0000, 0, 1, 5, 32'h7,          0,     0, 1, 8'h22, 32'h1234,      32'h0,         5); // 8 backpressure
    add(0, 1, 8'h33,  3, 4, 6, 16'h0000, 0, 0, 0, 32'h0,          0,     0, 1, 8'h22, 32'h1234,      32'h0,         5); // 9 hold
    add(0, 1, 8'h33,  3, 4, 6, 16'h0000, 0, 0, 0, 32'h0,          0,     0, 1, 8'h22, 32'h1234,      32'h0,         5); // 10 hold
    add(0, 1, 8'h33,  3, 4, 6, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h33, 32'h5,         32'h1234,      6); // 11 refill
    add(0, 1, 8'h44,  5, 3, 7, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h44, 32'h7,         32'h5,         7); // 12 back-to-back
    add(0, 0, 8'h00,  0, 0, 0, 16'h0000, 0, 1, 0, 32'hDEAD_BEEF,  1,     1, 0, 8'h44, 32'h7,         32'h5,         7); // 13 wb r0 dropped
    add(0, 1, 8'h55,  0, 0, 4, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h55, 32'h0,         32'h0,         4); // 14 r0 reads 0
    add(0, 0, 8'h00,  0, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0,     0, 1, 8'h55, 32'h0,         32'h0,         4); // 15 hold
    add(1, 1, 8'h66,  1, 2, 3, 16'h0000, 0, 1, 3, 32'h99,         1,     0, 0, 8'h00, 32'h0,         32'h0,         0); // 16 reset wins
    add(0, 1, 8'h77,  4, 3, 0, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h77, 32'h0,         32'h0,         0); // 17 r4 free, r3 cleared
    add(0, 1, 8'h88,  0, 0, 2, 16'h0000, 0, 1, 2, 32'h42,         1,     1, 1, 8'h88, 32'h0,         32'h0,         2); // 18 set beats clear
    add(0, 1, 8'h99,  2, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          1,     0, 0, 8'h88, 32'h0,         32'h0,         2); // 19 r2 busy
`ifdef OPFETCH_BYPASS_EN
    add(0, 1, 8'h99,  2, 0, 0, 16'h0000, 0, 1, 2, 32'h50,         1,     1, 1, 8'h99, 32'h50,        32'h0,         0); // 20 forwarded
`else
    add(0, 1, 8'h99,  2, 0, 0, 16'h0000, 0, 1, 2, 32'h50,         1,     0, 0, 8'h88, 32'h0,         32'h0,         2); // 20 still stalled
`endif
    add(0, 1, 8'h99,  2, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          1,     1, 1, 8'h99, 32'h50,        32'h0,         0); // 21 from regfile

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; in_valid = vq[i].iv; in_opcode = vq[i].op;
      in_rs = vq[i].rs; in_rt = vq[i].rt; in_rd = vq[i].rd;
      in_imm = vq[i].imm; in_use_imm = vq[i].ui;
      wb_en = vq[i].wbe; wb_addr = vq[i].wba; wb_data = vq[i].wbd;
      out_ready = vq[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vq[i].e_rdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i),  {31'd0, out_valid},  {31'd0, vq[i].e_ov});
      check($sformatf("v%0d out_opcode", i), {24'd0, out_opcode}, {24'd0, vq[i].e_op});
      check($sformatf("v%0d out_A", i),      out_A,               vq[i].e_a);
      check($sformatf("v%0d out_B", i),      out_B,               vq[i].e_b);
      check($sformatf("v%0d out_rd", i),     {28'd0, out_rd},     {28'd0, vq[i].e_rd});
    end

    // Hand sequence 1: source-B hazard resolved by a write-back two cycles in.
    @(negedge clk);
    idle_inputs();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 8'hA0; in_rd = 4'd9;
    @(posedge clk);
    @(negedge clk);
    in_opcode = 8'hA1; in_rs = 4'd0; in_rt = 4'd9; in_rd = 4'd0; in_use_imm = 1'b0;
    acc_cycle = -1;
    for (int k = 0; k < 6; k++) begin
      wb_en = (k == 2); wb_addr = 4'd9; wb_data = 32'h0000_CAFE;
      #1;
      if (in_ready) begin
        acc_cycle = k;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
`ifdef OPFETCH_BYPASS_EN
    exp_cycle = 2;
`else
    exp_cycle = 3;
`endif
    check("rt hazard accept cycle", acc_cycle, exp_cycle);
    @(posedge clk);
    #1;
    check("rt hazard out_valid",  {31'd0, out_valid}, 32'd1);
    check("rt hazard out_opcode", {24'd0, out_opcode}, 32'h0000_00A1);
    check("rt hazard out_B",      out_B, 32'h0000_CAFE);

    // Hand sequence 2: reset during a stall discards the pending output.
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; in_opcode = 8'hB0; in_rd = 4'd4;
    @(posedge clk);
    @(negedge clk);
    in_opcode = 8'hB1; in_rs = 4'd4; in_rd = 4'd0; out_ready = 1'b0;
    #1;
    check("pre-reset stall in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset out_valid",  {31'd0, out_valid}, 32'd0);
    check("reset out_opcode", {24'd0, out_opcode}, 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("post-reset rs4 in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("post-reset out_valid",  {31'd0, out_valid}, 32'd1);
    check("post-reset out_A",      out_A, 32'd0);
    check("post-reset out_opcode", {24'd0, out_opcode}, 32'h0000_00B1);

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
